wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback-side register file with pending-write scoreboard. Consumes the writeback-stage outputs of the cache/writeback pipeline latch (data, write enable, 32-bit write address), commits them into a 32x32 architectural register file, and serves two combinational read ports to decode with same-cycle write-first bypass. A per-register counter of in-flight writes drives a read-after-write and write-after-write hazard signal back to decode.

## Interface
- CNT_W, 2, width of each pending-write counter; maximum in-flight writes per register is 2^CNT_W-1

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- w_data_i  in  32  writeback data
- w_reg_write_enable_i  in  1  writeback commit strobe
- w_write_addr_i  in  32  writeback destination; bits [4:0] used, [31:5] ignored
- d_rs1_addr_i  in  5  decode read port 1 address
- d_rs2_addr_i  in  5  decode read port 2 address
- d_rs1_use_i  in  1  rs1 is a real source operand
- d_rs2_use_i  in  1  rs2 is a real source operand
- d_issue_i  in  1  decode instruction leaves decode this cycle
- d_rd_we_i  in  1  issuing instruction writes a register
- d_rd_addr_i  in  5  issuing instruction's destination
- flush_i  in  1  synchronous clear of all pending counters
- d_rs1_data_o  out  32  read data port 1
- d_rs2_data_o  out  32  read data port 2
- d_hazard_o  out  1  decode must not issue this cycle
- err_o  out  1  sticky protocol-violation flag

## Operation
- Register x0: reads 0; writes and issues targeting x0 ignored; pend[0] stays 0.
- Commit: w_reg_write_enable_i=1 and addr[4:0]!=0 -> regs[addr] <= w_data_i at edge.
- Read port n: if addr==0 -> 0; else if commit this cycle to same addr -> w_data_i (bypass); else regs[addr].
- Counters pend[1..31], CNT_W bits:
  - issue inc: d_issue_i & d_rd_we_i & rd!=0.
  - commit dec: w_reg_write_enable_i & addr!=0.
  - inc and dec same register same cycle -> unchanged.
  - dec at 0 -> counter held at 0, err_o set.
  - inc at max -> counter held at max, err_o set.
- Hazard (combinational): eff[r] = pend[r] minus 1 if a commit to r occurs this cycle, else pend[r]. d_hazard_o = (d_rs1_use_i & rs1!=0 & eff[rs1]!=0) | (d_rs2_use_i & rs2!=0 & eff[rs2]!=0) | (d_rd_we_i & rd!=0 & pend[rd]==max).
- d_issue_i while d_hazard_o=1: err_o set; the increment rules above still apply.
- flush_i: all counters cleared at edge; same-cycle issue/commit counter effects discarded; same-cycle commit data still written; err_o not cleared.
- err_o clears only on reset.

## Timing
- Reset (async, immediate): all regs 0, all pend 0, err_o 0; hence d_rs*_data_o=0, d_hazard_o depends only on max-count term (0).
- Commit-to-read: same cycle via bypass; from regfile the next cycle.
- Counter update visible one cycle after issue/commit edge; commit relief of hazard is same-cycle via eff.
- Read ports and d_hazard_o purely combinational from inputs and state; no added latency.
- Reset asserted mid-operation discards all pending state; writes in flight at deassertion edge are not committed until the next edge with enable.

## Test plan
- Reset then read x5, x0 -> both 0, d_hazard_o=0, err_o=0.
- Commit x3=0xDEADBEEF; same cycle rs1=3 -> 0xDEADBEEF (bypass); next cycle rs2=3 -> 0xDEADBEEF; commit to x0=0x1234 -> x0 still reads 0.
- Issue rd=7; next cycle rs1=7 use=1 -> d_hazard_o=1; cycle commit x7=0x55 arrives -> d_hazard_o=0 and rs1 data 0x55 same cycle.
- Issue rd=9 three times (CNT_W=2) -> pend=3, d_rd_we_i rd=9 gives d_hazard_o=1; fourth issue forced -> err_o=1, pend stays 3; issue+commit x9 same cycle -> pend stays 3.
- Commit x12 with pend[12]=0 -> err_o=1, data written; flush_i with pend[4]=2 plus same-cycle issue rd=4 -> pend[4]=0 next cycle, err_o remains 1.
- Assert rst_i asynchronously between edges with pending writes -> outputs 0 immediately, pend cleared, err_o 0.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: 32x32 writeback register file with bypassed reads and a pending-write hazard scoreboard
module wb_regfile #(
    parameter int CNT_W = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] w_data_i,
    input  logic        w_reg_write_enable_i,
    input  logic [31:0] w_write_addr_i,
    input  logic [4:0]  d_rs1_addr_i,
    input  logic [4:0]  d_rs2_addr_i,
    input  logic        d_rs1_use_i,
    input  logic        d_rs2_use_i,
    input  logic        d_issue_i,
    input  logic        d_rd_we_i,
    input  logic [4:0]  d_rd_addr_i,
    input  logic        flush_i,
    output logic [31:0] d_rs1_data_o,
    output logic [31:0] d_rs2_data_o,
    output logic        d_hazard_o,
    output logic        err_o
);
    localparam logic [CNT_W-1:0] PEND_MAX = '1;
    logic [31:0]      regs_q [32];
    logic [31:0]      regs_d [32];
    logic [CNT_W-1:0] pend_q [32];
    logic [CNT_W-1:0] pend_d [32];
    logic             err_q, err_d;
    logic [4:0]       w_addr;
    logic             commit, inc;
    logic [31:0]      inc_v, dec_v;
    logic [CNT_W-1:0] eff1, eff2;
    logic             unused_addr_hi;
    assign unused_addr_hi = ^w_write_addr_i[31:5];
    assign w_addr = w_write_addr_i[4:0];
    assign commit = w_reg_write_enable_i && w_addr != 5'd0;
    assign inc    = d_issue_i && d_rd_we_i && d_rd_addr_i != 5'd0;
    assign inc_v  = inc ? 32'd1 << d_rd_addr_i : 32'd0;
    assign dec_v  = commit ? 32'd1 << w_addr : 32'd0;
    // a commit landing this cycle already relieves the hazard it resolves
    assign eff1 = pend_q[d_rs1_addr_i] - CNT_W'(dec_v[d_rs1_addr_i]);
    assign eff2 = pend_q[d_rs2_addr_i] - CNT_W'(dec_v[d_rs2_addr_i]);
    assign d_rs1_data_o = d_rs1_addr_i == 5'd0 ? 32'd0 :
                          dec_v[d_rs1_addr_i] ? w_data_i : regs_q[d_rs1_addr_i];
    assign d_rs2_data_o = d_rs2_addr_i == 5'd0 ? 32'd0 :
                          dec_v[d_rs2_addr_i] ? w_data_i : regs_q[d_rs2_addr_i];
    assign d_hazard_o = (d_rs1_use_i && d_rs1_addr_i != 5'd0 && eff1 != '0) ||
                        (d_rs2_use_i && d_rs2_addr_i != 5'd0 && eff2 != '0) ||
                        (d_rd_we_i && d_rd_addr_i != 5'd0 && pend_q[d_rd_addr_i] == PEND_MAX);
    assign err_o = err_q;
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        err_d  = err_q || (d_issue_i && d_hazard_o);
        if (commit) regs_d[w_addr] = w_data_i;
        for (int r = 1; r < 32; r++) begin
            if (inc_v[r] && !dec_v[r]) begin
                if (pend_q[r] == PEND_MAX) err_d = 1'b1;
                else pend_d[r] = pend_q[r] + 1'b1;
            end else if (dec_v[r] && !inc_v[r]) begin
                if (pend_q[r] == '0) err_d = 1'b1;
                else pend_d[r] = pend_q[r] - 1'b1;
            end
        end
        if (flush_i) pend_d = '{default: '0};
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            regs_q <= '{default: '0};
            pend_q <= '{default: '0};
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scoreboard bench for wb_regfile against an array-based reference model
module tb_wb_regfile;
    localparam int CNT_W = 2;
    localparam int PMAX = (1 << CNT_W) - 1;
    logic        clk_i, rst_i;
    logic [31:0] w_data_i, w_write_addr_i;
    logic        w_reg_write_enable_i;
    logic [4:0]  d_rs1_addr_i, d_rs2_addr_i, d_rd_addr_i;
    logic        d_rs1_use_i, d_rs2_use_i, d_issue_i, d_rd_we_i, flush_i;
    logic [31:0] d_rs1_data_o, d_rs2_data_o;
    logic        d_hazard_o, err_o;

    wb_regfile #(.CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .w_data_i(w_data_i), .w_reg_write_enable_i(w_reg_write_enable_i),
        .w_write_addr_i(w_write_addr_i),
        .d_rs1_addr_i(d_rs1_addr_i), .d_rs2_addr_i(d_rs2_addr_i),
        .d_rs1_use_i(d_rs1_use_i), .d_rs2_use_i(d_rs2_use_i),
        .d_issue_i(d_issue_i), .d_rd_we_i(d_rd_we_i), .d_rd_addr_i(d_rd_addr_i),
        .flush_i(flush_i),
        .d_rs1_data_o(d_rs1_data_o), .d_rs2_data_o(d_rs2_data_o),
        .d_hazard_o(d_hazard_o), .err_o(err_o)
    );

    typedef struct {
        logic [31:0] r1, r2;
        logic        haz, err;
        int          id;
    } exp_t;

    typedef struct {
        bit          we;
        logic [31:0] wd, wa;
        logic [4:0]  rs1, rs2, rd;
        bit          u1, u2, iss, rdwe, fl;
    } stim_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          step_no = 0;
    logic [31:0] m_regs [32];
    int          m_pend [32];
    bit          m_err;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int id);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
        end
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 0;
        end
        m_err = 1'b0;
    endfunction

    function automatic bit model_haz(input stim_t s);
        int wa = int'(s.wa[4:0]);
        bit c = s.we && wa != 0;
        int e1 = m_pend[s.rs1] - ((c && wa == int'(s.rs1)) ? 1 : 0);
        int e2 = m_pend[s.rs2] - ((c && wa == int'(s.rs2)) ? 1 : 0);
        return (s.u1 && s.rs1 != 0 && e1 != 0) || (s.u2 && s.rs2 != 0 && e2 != 0) ||
               (s.rdwe && s.rd != 0 && m_pend[s.rd] == PMAX);
    endfunction

    task automatic step(input stim_t s_in, input bit gate);
        stim_t s = s_in;
        exp_t  e;
        bit    h, c, up;
        int    wa;
        @(negedge clk_i);
        h = model_haz(s);
        if (gate && h) s.iss = 1'b0;
        w_reg_write_enable_i = s.we; w_data_i = s.wd; w_write_addr_i = s.wa;
        d_rs1_addr_i = s.rs1; d_rs2_addr_i = s.rs2; d_rs1_use_i = s.u1; d_rs2_use_i = s.u2;
        d_issue_i = s.iss; d_rd_we_i = s.rdwe; d_rd_addr_i = s.rd; flush_i = s.fl;
        wa = int'(s.wa[4:0]);
        c = s.we && wa != 0;
        e.r1 = s.rs1 == 0 ? 32'd0 : (c && wa == int'(s.rs1)) ? s.wd : m_regs[s.rs1];
        e.r2 = s.rs2 == 0 ? 32'd0 : (c && wa == int'(s.rs2)) ? s.wd : m_regs[s.rs2];
        e.haz = h;
        e.err = m_err;
        e.id = step_no++;
        q.push_back(e);
        if (s.iss && h) m_err = 1'b1;
        up = s.iss && s.rdwe && s.rd != 0;
        if (s.fl) begin
            for (int i = 0; i < 32; i++) m_pend[i] = 0;
        end else begin
            if (up && !(c && wa == int'(s.rd))) begin
                if (m_pend[s.rd] == PMAX) m_err = 1'b1;
                else m_pend[s.rd]++;
            end
            if (c && !(up && wa == int'(s.rd))) begin
                if (m_pend[wa] == 0) m_err = 1'b1;
                else m_pend[wa]--;
            end
        end
        if (c) m_regs[wa] = s.wd;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rs1_data", d_rs1_data_o, e.r1, e.id);
                chk("rs2_data", d_rs2_data_o, e.r2, e.id);
                chk("hazard", 32'(d_hazard_o), 32'(e.haz), e.id);
                chk("err", 32'(err_o), 32'(e.err), e.id);
            end
        end
    end

    initial begin
        stim_t s;
        int    pend_list[$];
        int    k;
        rst_i = 1'b1;
        w_reg_write_enable_i = 0; w_data_i = 0; w_write_addr_i = 0;
        d_rs1_addr_i = 5'd5; d_rs2_addr_i = 5'd0; d_rs1_use_i = 1; d_rs2_use_i = 1;
        d_issue_i = 0; d_rd_we_i = 0; d_rd_addr_i = 0; flush_i = 0;
        model_reset();
        #1;
        chk("reset_rs1", d_rs1_data_o, 32'd0, -1);
        chk("reset_rs2", d_rs2_data_o, 32'd0, -1);
        chk("reset_hazard", 32'(d_hazard_o), 32'd0, -1);
        chk("reset_err", 32'(err_o), 32'd0, -1);
        @(negedge clk_i);
        rst_i = 1'b0;

        s = idle(); s.we = 1; s.wd = 32'hDEADBEEF; s.wa = 32'd3; s.rs1 = 3; step(s, 0);
        s = idle(); s.rs2 = 3; s.we = 1; s.wd = 32'h1234; s.wa = 32'd0; step(s, 0);
        s = idle(); s.rs1 = 0; s.rs2 = 3; s.u1 = 1; step(s, 0);

        s = idle(); s.iss = 1; s.rdwe = 1; s.rd = 7; step(s, 0);
        s = idle(); s.rs1 = 7; s.u1 = 1; step(s, 0);
        s = idle(); s.rs1 = 7; s.u1 = 1; s.we = 1; s.wd = 32'h55; s.wa = 32'hFFFF_FFE7; step(s, 0);
        s = idle(); s.rs1 = 7; s.u1 = 1; step(s, 0);

        for (int i = 0; i < 3; i++) begin
            s = idle(); s.iss = 1; s.rdwe = 1; s.rd = 9; step(s, 0);
        end
        s = idle(); s.rdwe = 1; s.rd = 9; step(s, 0);
        s = idle(); s.iss = 1; s.rdwe = 1; s.rd = 9; step(s, 0);
        s = idle(); s.rdwe = 1; s.rd = 9; step(s, 0);
        s = idle(); s.iss = 1; s.rdwe = 1; s.rd = 9; s.we = 1; s.wd = 32'h99; s.wa = 32'd9; step(s, 0);
        s = idle(); s.rdwe = 1; s.rd = 9; s.rs2 = 9; s.u2 = 1; step(s, 0);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.we = 1; s.wd = 32'h900 + 32'(i); s.wa = 32'd9; s.rs1 = 9; s.u1 = 1; step(s, 0);
        end
        s = idle(); s.rdwe = 1; s.rd = 9; s.rs1 = 9; s.u1 = 1; step(s, 0);

        s = idle(); s.iss = 1; s.rdwe = 1; s.rd = 7; step(s, 0);
        @(negedge clk_i);
        #3;
        d_rs1_addr_i = 5'd3; d_rs2_addr_i = 5'd7; d_rs1_use_i = 1; d_rs2_use_i = 1;
        d_rd_we_i = 1; d_rd_addr_i = 5'd9; d_issue_i = 0; w_reg_write_enable_i = 0; flush_i = 0;
        rst_i = 1'b1;
        #1;
        chk("async_rs1", d_rs1_data_o, 32'd0, -2);
        chk("async_rs2", d_rs2_data_o, 32'd0, -2);
        chk("async_hazard", 32'(d_hazard_o), 32'd0, -2);
        chk("async_err", 32'(err_o), 32'd0, -2);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        s = idle(); s.rs1 = 3; s.rs2 = 7; s.u1 = 1; s.u2 = 1; step(s, 0);

        s = idle(); s.we = 1; s.wd = 32'hA5A5_0012; s.wa = 32'd12; step(s, 0);
        s = idle(); s.rs1 = 12; step(s, 0);
        s = idle(); s.iss = 1; s.rdwe = 1; s.rd = 4; step(s, 0);
        s = idle(); s.iss = 1; s.rdwe = 1; s.rd = 4; step(s, 0);
        s = idle(); s.rs1 = 4; s.u1 = 1; s.iss = 0; step(s, 0);
        s = idle(); s.fl = 1; s.iss = 1; s.rdwe = 1; s.rd = 4; step(s, 0);
        s = idle(); s.rs1 = 4; s.u1 = 1; s.rdwe = 1; s.rd = 4; step(s, 0);

        @(negedge clk_i);
        #3;
        rst_i = 1'b1;
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int n = 0; n < 400; n++) begin
            s = idle();
            pend_list.delete();
            for (int r = 1; r < 32; r++) if (m_pend[r] > 0) pend_list.push_back(r);
            s.wd = $urandom;
            if (pend_list.size() > 0 && $urandom_range(0, 1) == 1) begin
                k = pend_list[$urandom_range(0, pend_list.size() - 1)];
                s.we = 1;
                s.wa = {27'($urandom), 5'(k)};
            end else begin
                s.we = $urandom_range(0, 3) == 0;
                s.wa = {27'($urandom), 5'd0};
            end
            s.rs1 = 5'($urandom); s.rs2 = 5'($urandom); s.rd = 5'($urandom_range(0, 15));
            s.u1 = $urandom_range(0, 1) == 1; s.u2 = $urandom_range(0, 1) == 1;
            s.rdwe = $urandom_range(0, 3) != 0; s.iss = $urandom_range(0, 1) == 1;
            s.fl = $urandom_range(0, 49) == 0;
            step(s, 1);
        end

        repeat (4) @(negedge clk_i);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
